// File: rtl/debug_dmi_bridge_if.sv
// Bundles the request CDC, response CDC and debug-module register port of the DMI bridge.
// master = the bridge; slave = the CDC FIFOs and debug module around it.
interface debug_dmi_bridge_if #(
   parameter int ABITS = 7
);
   // Request side: a transfer happens on a clock edge where REQ_RDY and REQ_GET are both 1.
   // Response side: RSP_PUT is the valid; a beat is consumed on an edge where RSP_RDY is 1.
   // RSP_DATA is held stable while RSP_PUT waits for RSP_RDY.
   // DMI side: DMI_REQ is held with stable command fields until a one-cycle DMI_ACK.
   logic               REQ_RDY;
   logic               REQ_GET;
   logic [ABITS+33:0]  REQ_DATA;
   logic               RSP_PUT;
   logic               RSP_RDY;
   logic [33:0]        RSP_DATA;
   logic               DMI_REQ;
   logic               DMI_WR;
   logic [ABITS-1:0]   DMI_ADDR;
   logic [31:0]        DMI_WDATA;
   logic               DMI_ACK;
   logic [31:0]        DMI_RDATA;
   logic               DMI_ERR;

   modport master (
      input  REQ_RDY, REQ_DATA, RSP_RDY, DMI_ACK, DMI_RDATA, DMI_ERR,
      output REQ_GET, RSP_PUT, RSP_DATA, DMI_REQ, DMI_WR, DMI_ADDR, DMI_WDATA
   );

   modport slave (
      output REQ_RDY, REQ_DATA, RSP_RDY, DMI_ACK, DMI_RDATA, DMI_ERR,
      input  REQ_GET, RSP_PUT, RSP_DATA, DMI_REQ, DMI_WR, DMI_ADDR, DMI_WDATA
   );
endinterface

// File: rtl/debug_dmi_bridge.sv
// DMI bridge: turns one CDC request at a time into a debug-module register access and a response.
// Optional macro DEBUG_DMI_TIMEOUT_EN aborts a bus access after 256 cycles without DMI_ACK.
module debug_dmi_bridge #(
   parameter int ABITS = 7
) (
   input  logic                  CLK,
   input  logic                  RES,
   debug_dmi_bridge_if.master    bus,
   output logic [1:0]            state_dbg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [1:0] OP_NOP   = 2'd0;
   localparam logic [1:0] OP_READ  = 2'd1;
   localparam logic [1:0] OP_WRITE = 2'd2;

   localparam logic [1:0] ST_OK    = 2'd0;
   localparam logic [1:0] ST_FAIL  = 2'd2;
   localparam logic [1:0] ST_BUSY  = 2'd3;

   state_t              state_q, state_d;
   logic                wr_q, wr_d;
   logic [ABITS-1:0]    addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [33:0]         rsp_q, rsp_d;
   logic                take;
   logic [1:0]          op;
   logic                in_bus;
   logic                in_resp;

`ifdef DEBUG_DMI_TIMEOUT_EN
   logic [7:0]          cnt_q, cnt_d;
`endif

   assign take = bus.REQ_RDY && (state_q == IDLE);
   assign op   = bus.REQ_DATA[1:0];

   always_ff @(posedge CLK) begin
      if (RES) begin
         state_q <= IDLE;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rsp_q   <= '0;
`ifdef DEBUG_DMI_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rsp_q   <= rsp_d;
`ifdef DEBUG_DMI_TIMEOUT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rsp_d   = rsp_q;
`ifdef DEBUG_DMI_TIMEOUT_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (take) begin
               addr_d  = bus.REQ_DATA[ABITS+33:34];
               wdata_d = bus.REQ_DATA[33:2];
               wr_d    = (op == OP_WRITE);
               // nop and reserved ops answer directly without touching the bus
               if (op == OP_NOP) begin
                  rsp_d   = {32'h0, ST_OK};
                  state_d = RESP;
               end else if (op == OP_READ || op == OP_WRITE) begin
                  rsp_d   = '0;
                  state_d = BUS;
`ifdef DEBUG_DMI_TIMEOUT_EN
                  cnt_d   = '0;
`endif
               end else begin
                  rsp_d   = {32'h0, ST_FAIL};
                  state_d = RESP;
               end
            end
         end
         BUS: begin
            if (bus.DMI_ACK) begin
               rsp_d[33:2] = (!wr_q && !bus.DMI_ERR) ? bus.DMI_RDATA : 32'h0;
               rsp_d[1:0]  = bus.DMI_ERR ? ST_FAIL : ST_OK;
               state_d     = RESP;
            end
`ifdef DEBUG_DMI_TIMEOUT_EN
            // cnt_q == 255 marks the 256th unacknowledged bus cycle
            else if (cnt_q == 8'hFF) begin
               rsp_d   = {32'h0, ST_BUSY};
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
`endif
         end
         RESP: begin
            if (bus.RSP_RDY) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs are forced low while RES is asserted, independent of register contents.
   assign in_bus        = (state_q == BUS) && !RES;
   assign in_resp       = (state_q == RESP) && !RES;

   assign bus.REQ_GET   = take && !RES;
   assign bus.DMI_REQ   = in_bus;
   assign bus.DMI_WR    = in_bus && wr_q;
   assign bus.DMI_ADDR  = in_bus ? addr_q : '0;
   assign bus.DMI_WDATA = in_bus ? wdata_q : 32'h0;
   assign bus.RSP_PUT   = in_resp;
   assign bus.RSP_DATA  = in_resp ? rsp_q : 34'h0;

   assign state_dbg     = state_q;

endmodule

// File: doc/debug_dmi_bridge.md
DEBUG_DMI_BRIDGE -- requirements
Module: debug_dmi_bridge

Interface
REQ-001 SHALL have parameter ABITS, default 7, DMI address width.
REQ-002 SHALL have port CLK  in  1  single clock for all logic.
REQ-003 SHALL have port RES  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port REQ_RDY  in  1  DMI request available, from the CDC read side.
REQ-005 SHALL have port REQ_GET  out  1  consume request, to the CDC read side.
REQ-006 SHALL have port REQ_DATA  in  ABITS+34  request {addr[ABITS+33:34], data[33:2], op[1:0]}.
REQ-007 SHALL have port RSP_PUT  out  1  response valid, to the response CDC write side.
REQ-008 SHALL have port RSP_RDY  in  1  response CDC can accept.
REQ-009 SHALL have port RSP_DATA  out  34  response {data[33:2], status[1:0]}.
REQ-010 SHALL have port DMI_REQ  out  1  register access strobe to the debug module.
REQ-011 SHALL have port DMI_WR  out  1  1 = write, 0 = read.
REQ-012 SHALL have port DMI_ADDR  out  ABITS  register address.
REQ-013 SHALL have port DMI_WDATA  out  32  write data.
REQ-014 SHALL have port DMI_ACK  in  1  access complete, single-cycle pulse.
REQ-015 SHALL have port DMI_RDATA  in  32  read data, valid with DMI_ACK.
REQ-016 SHALL have port DMI_ERR  in  1  access error, valid with DMI_ACK.

Function
REQ-017 SHALL implement FSM states IDLE, BUS, RESP; one request in flight at a time.
REQ-018 SHALL drive REQ_GET = REQ_RDY & (state == IDLE), combinationally, and capture REQ_DATA into internal registers on that edge.
REQ-019 SHALL decode op: 0 nop -> RESP, data 0, status 0, no bus access; 1 read -> BUS; 2 write -> BUS; 3 reserved -> RESP, data 0, status 2, no bus access.
REQ-020 SHALL hold DMI_REQ = 1 with stable DMI_WR/DMI_ADDR/DMI_WDATA throughout BUS; DMI_REQ is 0 in all other states.
REQ-021 SHALL sample DMI_ACK in BUS, including the first BUS cycle (zero-wait ack allowed); on ack go to RESP with status = DMI_ERR ? 2 : 0.
REQ-022 SHALL set response data = DMI_RDATA for an acked read, and 0 for writes, nops, and failures.
REQ-023 SHALL hold RSP_PUT = 1 with stable RSP_DATA throughout RESP, and return to IDLE on the first cycle with RSP_RDY = 1.
REQ-024 SHALL ignore DMI_ACK outside BUS.
REQ-025 SHALL accept no new request before RESP completes; a new request SHALL be taken at earliest on the cycle the FSM is back in IDLE.
REQ-026 SHALL produce, for a nop with RSP_RDY held at 1, REQ_GET in cycle 0, RSP_PUT in cycle 1, and REQ_GET again at earliest in cycle 2.
REQ-027 SHALL produce, for a read with DMI_ACK in the first BUS cycle, DMI_REQ in cycle 1 and RSP_PUT in cycle 2.

Reset
REQ-028 SHALL, on CLK rising edge with RES = 1, enter IDLE and clear all internal registers to 0.
REQ-029 SHALL drive REQ_GET, RSP_PUT, DMI_REQ, DMI_WR, DMI_ADDR, DMI_WDATA, and RSP_DATA to 0 while RES = 1.
REQ-030 SHALL, on reset in BUS or RESP, drop the in-flight request with no response issued.

Configuration
REQ-031 SHALL, with DEBUG_DMI_TIMEOUT_EN defined, run an 8-bit counter that clears on BUS entry and increments each BUS cycle without DMI_ACK.
REQ-032 SHALL, with DEBUG_DMI_TIMEOUT_EN defined, treat the 256th BUS cycle without DMI_ACK as an abort: DMI_REQ falls the next cycle and the FSM enters RESP with data 0, status 3.
REQ-033 SHALL, without DEBUG_DMI_TIMEOUT_EN, have no counter and wait in BUS indefinitely.

Verification
REQ-034 Nop: REQ_DATA op = 0, RSP_RDY = 1 -> no DMI_REQ; RSP_DATA = 34'h0 one cycle after REQ_GET.
REQ-035 Read: addr 7'h11, DMI_ACK on the first BUS cycle with DMI_RDATA = 32'hDEADBEEF and DMI_ERR = 0 -> RSP_DATA = {32'hDEADBEEF, 2'b00}.
REQ-036 Write: addr 7'h10, data 32'h0000_0001, DMI_ACK after 5 cycles with DMI_ERR = 1 -> DMI_WR = 1 for 6 cycles; RSP_DATA = {32'h0, 2'b10}.
REQ-037 Backpressure: RSP_RDY low for 10 cycles while REQ_RDY = 1 -> RSP_PUT and RSP_DATA held stable; REQ_GET stays 0 until the cycle after RSP_RDY rises.
REQ-038 Reset: RES pulse during BUS -> all outputs 0 next cycle; a late DMI_ACK is ignored; the next request completes normally.
REQ-039 Timeout, with DEBUG_DMI_TIMEOUT_EN defined: read with no ack -> DMI_REQ high for 256 cycles; RSP_DATA = {32'h0, 2'b11}. Without the macro, DMI_REQ stays high for more than 1000 cycles.
